// File: rtl/sprite_pixel_streamer.sv
// Sprite pixel streamer: fetches packed words per sprite channel and streams pixels MS-first over valid/ready.
// Optional colour-key output enabled by defining SPRITE_STREAMER_TRANSPARENCY_EN.
module sprite_pixel_streamer #(
   parameter int NUM_SPRITES  = 8,
   parameter int PIX_W        = 24,
   parameter int PIX_PER_WORD = 2,
   parameter int ADDR_W       = 16,
   parameter int RD_LATENCY   = 1,
   parameter int SEL_W        = $clog2(NUM_SPRITES)
`ifdef SPRITE_STREAMER_TRANSPARENCY_EN
   ,
   parameter logic [PIX_W-1:0] KEY_COLOR = 24'hFF00FF
`endif
) (
   input  logic                          CLK,
   input  logic                          RESET_N,
   input  logic                          START,
   input  logic [NUM_SPRITES-1:0]        SPRITES_EN,
   input  logic [NUM_SPRITES*ADDR_W-1:0] SPRITE_LEN,
   input  logic [PIX_W*PIX_PER_WORD-1:0] DATA_IN,
   input  logic                          PIX_READY,
   output logic                          MEM_RD,
   output logic [ADDR_W-1:0]             MEM_ADDR,
   output logic [SEL_W-1:0]              MEM_SEL,
   output logic [PIX_W-1:0]              RGB,
   output logic                          PIX_VALID,
   output logic                          PIX_LAST,
   output logic                          BUSY,
   output logic                          DONE
`ifdef SPRITE_STREAMER_TRANSPARENCY_EN
   ,
   output logic                          PIX_OPAQUE
`endif
);

   localparam int WORD_W = PIX_W * PIX_PER_WORD;
   localparam int PCNT_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
   localparam int LCNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
   localparam logic [PCNT_W-1:0] PIX_MAX = PCNT_W'(PIX_PER_WORD - 1);
   localparam logic [LCNT_W-1:0] LAT_MAX = LCNT_W'(RD_LATENCY - 1);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, SHIFT, FIN} state_t;

   state_t              state, next_state;
   logic [SEL_W-1:0]    sel, win_sel;
   logic [ADDR_W-1:0]   addr [NUM_SPRITES];
   logic [ADDR_W-1:0]   win_len, sel_len;
   logic [WORD_W-1:0]   shift_reg;
   logic [PCNT_W-1:0]   pix_cnt;
   logic [LCNT_W-1:0]   lat_cnt;
   logic                last_word;
   logic                lat_done, word_done;

   // Lowest enabled channel wins; with nothing enabled channel 0 is used.
   always_comb begin
      win_sel = '0;
      for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
         if (SPRITES_EN[i]) win_sel = SEL_W'(i);
      end
   end

   assign win_len   = SPRITE_LEN[int'(win_sel)*ADDR_W +: ADDR_W];
   assign sel_len   = SPRITE_LEN[int'(sel)*ADDR_W +: ADDR_W];
   assign lat_done  = (lat_cnt == LAT_MAX);
   assign word_done = (state == SHIFT) && PIX_READY && (pix_cnt == PIX_MAX);

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) state <= IDLE;
      else          state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (START) next_state = (win_len == '0) ? FIN : REQ;
         REQ:     next_state = WAIT;
         WAIT:    if (lat_done) next_state = SHIFT;
         SHIFT:   if (word_done) next_state = last_word ? FIN : REQ;
         FIN:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // The end-of-sprite decision is registered at capture so PIX_LAST never depends on a live input.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         sel       <= '0;
         shift_reg <= '0;
         pix_cnt   <= '0;
         lat_cnt   <= '0;
         last_word <= 1'b0;
         for (int i = 0; i < NUM_SPRITES; i++) addr[i] <= '0;
      end else begin
         case (state)
            IDLE: if (START) sel <= win_sel;
            REQ:  lat_cnt <= '0;
            WAIT: begin
               lat_cnt <= lat_cnt + LCNT_W'(1);
               if (lat_done) begin
                  shift_reg <= DATA_IN;
                  pix_cnt   <= '0;
                  last_word <= (addr[sel] == sel_len - ADDR_W'(1));
               end
            end
            SHIFT: if (PIX_READY) begin
               if (pix_cnt == PIX_MAX) begin
                  addr[sel] <= last_word ? '0 : addr[sel] + ADDR_W'(1);
               end else begin
                  shift_reg <= shift_reg << PIX_W;
                  pix_cnt   <= pix_cnt + PCNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign MEM_RD    = (state == REQ);
   assign MEM_ADDR  = addr[sel];
   assign MEM_SEL   = sel;
   assign RGB       = shift_reg[WORD_W-1 -: PIX_W];
   assign PIX_VALID = (state == SHIFT);
   assign PIX_LAST  = PIX_VALID && last_word && (pix_cnt == PIX_MAX);
   assign BUSY      = (state != IDLE);
   assign DONE      = (state == FIN);

`ifdef SPRITE_STREAMER_TRANSPARENCY_EN
   assign PIX_OPAQUE = PIX_VALID && (RGB != KEY_COLOR);
`endif

endmodule
